// File: rtl/isr_trap_seq.sv
// Exception entry / return-from-exception sequencer: saves and restores control
// registers, swaps the stack pointer and redirects fetch to the vector or saved PC.
module isr_trap_seq #(
    parameter int VEC_SHIFT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        exc_req,
    input  logic [15:0] exc_code,
    input  logic [63:0] exc_tea,
    input  logic        rte_req,
    input  logic [47:0] cur_pc,
    input  logic [63:0] cur_sr,
    input  logic [63:0] cur_exsr,
    input  logic [47:0] cur_spc,
    input  logic [47:0] cur_ssp,
    input  logic [63:0] cur_tea,
    input  logic [47:0] cur_vbr,
    input  logic [47:0] cur_sp,
    output logic [63:0] out_sr,
    output logic [63:0] out_exsr,
    output logic [47:0] out_spc,
    output logic [47:0] out_ssp,
    output logic [63:0] out_tea,
    output logic        sp_wr,
    output logic [47:0] sp_val,
    output logic        redir,
    output logic [47:0] redir_pc,
    output logic        flush,
    output logic        exc_ack,
    output logic        rte_ack,
    output logic        busy,
    output logic        lockup
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        E_SAVE  = 3'd1,
        E_REDIR = 3'd2,
        R_SAVE  = 3'd3,
        R_REDIR = 3'd4,
        LOCK    = 3'd5
    } state_t;

    state_t      state;
    logic [47:0] pc_q;      // faulting PC on entry, saved SPC on return
    logic [63:0] sr_q;
    logic [47:0] sp_q;
    logic [47:0] ssp_q;
    logic [15:0] code_q;
    logic [63:0] tea_q;
    logic [47:0] vbr_q;
    logic [31:0] exsr_hi_q;
    logic [47:0] vec_pc;

    assign vec_pc = vbr_q + (48'(code_q[15:12]) << VEC_SHIFT);
    assign busy   = (state != IDLE);
    assign sp_val = ssp_q;

    // NOTE: every register here is assigned with <= so all of them sample the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lockup    <= 1'b0;
            sp_wr     <= 1'b0;
            redir     <= 1'b0;
            flush     <= 1'b0;
            exc_ack   <= 1'b0;
            rte_ack   <= 1'b0;
            pc_q      <= '0;
            sr_q      <= '0;
            sp_q      <= '0;
            ssp_q     <= '0;
            code_q    <= '0;
            tea_q     <= '0;
            vbr_q     <= '0;
            exsr_hi_q <= '0;
        end else if (!hold) begin
            sp_wr   <= 1'b0;
            redir   <= 1'b0;
            flush   <= 1'b0;
            exc_ack <= 1'b0;
            rte_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_req) begin
                        if (cur_sr[28]) begin
                            state  <= LOCK;
                            lockup <= 1'b1;
                        end else begin
                            pc_q   <= cur_pc;
                            sr_q   <= cur_sr;
                            sp_q   <= cur_sp;
                            ssp_q  <= cur_ssp;
                            code_q <= exc_code;
                            tea_q  <= exc_tea;
                            vbr_q  <= cur_vbr;
                            state  <= E_SAVE;
                            sp_wr  <= 1'b1;
                            flush  <= 1'b1;
                        end
                    end else if (rte_req && !rte_ack) begin
                        // rte_ack guard stops a still-held request from re-pulsing
                        if (cur_sr[28]) begin
                            exsr_hi_q <= cur_exsr[63:32];
                            pc_q      <= cur_spc;
                            sp_q      <= cur_sp;
                            ssp_q     <= cur_ssp;
                            sr_q      <= cur_sr;
                            state     <= R_SAVE;
                            sp_wr     <= 1'b1;
                            flush     <= 1'b1;
                        end else begin
                            rte_ack <= 1'b1;
                        end
                    end
                end
                E_SAVE: begin
                    state   <= E_REDIR;
                    redir   <= 1'b1;
                    exc_ack <= 1'b1;
                    flush   <= 1'b1;
                end
                R_SAVE: begin
                    state   <= R_REDIR;
                    redir   <= 1'b1;
                    rte_ack <= 1'b1;
                    flush   <= 1'b1;
                end
                E_REDIR, R_REDIR: state <= IDLE;
                LOCK:             state <= LOCK;
                default:          state <= IDLE;
            endcase
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        out_sr   = cur_sr;
        out_exsr = cur_exsr;
        out_spc  = cur_spc;
        out_ssp  = cur_ssp;
        out_tea  = cur_tea;
        redir_pc = (state == R_REDIR) ? pc_q : vec_pc;
        case (state)
            E_SAVE: begin
                out_spc  = pc_q;
                out_exsr = {sr_q[31:0], 16'h0, code_q};
                out_tea  = tea_q;
                out_ssp  = sp_q;
                out_sr   = sr_q | 64'h0000_0000_7000_0000;
            end
            R_SAVE: begin
                out_sr  = {sr_q[63:32], exsr_hi_q};
                out_ssp = sp_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_isr_trap_seq.sv
// Scoreboard bench for isr_trap_seq: a small CR-file model feeds back the out_*
// values, and each expected ack/redirect is queued when the request is driven.
module tb_isr_trap_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic        exc_req = 1'b0;
    logic [15:0] exc_code = '0;
    logic [63:0] exc_tea = '0;
    logic        rte_req = 1'b0;
    logic [47:0] cur_pc = '0;
    logic [63:0] cr_sr = '0;
    logic [63:0] cr_exsr = '0;
    logic [47:0] cr_spc = '0;
    logic [47:0] cr_ssp = '0;
    logic [63:0] cr_tea = '0;
    logic [47:0] cr_vbr = '0;
    logic [47:0] cr_sp = '0;

    logic [63:0] out_sr, out_exsr, out_tea;
    logic [47:0] out_spc, out_ssp, sp_val, redir_pc;
    logic        sp_wr, redir, flush, exc_ack, rte_ack, busy, lockup;

    typedef struct {
        logic        is_exc;
        logic [47:0] pc;
        logic        redir;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   redir_count = 0;
    int   n_exc_ack = 0;
    int   snap;

    isr_trap_seq #(.VEC_SHIFT(3)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .exc_req(exc_req), .exc_code(exc_code), .exc_tea(exc_tea),
        .rte_req(rte_req), .cur_pc(cur_pc),
        .cur_sr(cr_sr), .cur_exsr(cr_exsr), .cur_spc(cr_spc), .cur_ssp(cr_ssp),
        .cur_tea(cr_tea), .cur_vbr(cr_vbr), .cur_sp(cr_sp),
        .out_sr(out_sr), .out_exsr(out_exsr), .out_spc(out_spc), .out_ssp(out_ssp),
        .out_tea(out_tea), .sp_wr(sp_wr), .sp_val(sp_val), .redir(redir),
        .redir_pc(redir_pc), .flush(flush), .exc_ack(exc_ack), .rte_ack(rte_ack),
        .busy(busy), .lockup(lockup)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One clock: capture CR writes, clock, apply them, then score any ack.
    task automatic step();
        logic [63:0] w_sr, w_exsr, w_tea;
        logic [47:0] w_spc, w_ssp, w_sp;
        logic        w_spwr;
        exp_t        e;
        #1;
        w_sr = out_sr; w_exsr = out_exsr; w_tea = out_tea;
        w_spc = out_spc; w_ssp = out_ssp; w_sp = sp_val; w_spwr = sp_wr;
        @(posedge clock);
        #1;
        cr_sr = w_sr; cr_exsr = w_exsr; cr_tea = w_tea;
        cr_spc = w_spc; cr_ssp = w_ssp;
        if (w_spwr === 1'b1) cr_sp = w_sp;
        #1;
        if (redir) redir_count++;
        if (exc_ack || rte_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", {62'h0, exc_ack, rte_ack}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                check("ack_kind", {62'h0, exc_ack, rte_ack}, e.is_exc ? 64'h2 : 64'h1);
                check("ack_redir", redir, e.redir);
                check("ack_flush", flush, e.redir);
                if (e.redir) check("ack_redir_pc", redir_pc, e.pc);
            end
        end
        if (exc_ack) begin
            exc_req = 1'b0;
            n_exc_ack++;
        end
        if (rte_ack) rte_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) step();
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        // Reset: strobes low, out_* pass through while reset is still high
        cr_tea = 64'h1122_3344_5566_7788;
        cr_exsr = 64'h0bad_cafe_0000_0001;
        cr_spc = 48'h0000_1234_5678;
        step();
        check("rst_busy", busy, 0);
        check("rst_lockup", lockup, 0);
        check("rst_strobes", {sp_wr, redir, flush, exc_ack, rte_ack}, 0);
        check("rst_tea_pass", out_tea, 64'h1122_3344_5566_7788);
        check("rst_exsr_pass", out_exsr, 64'h0bad_cafe_0000_0001);
        check("rst_spc_pass", out_spc, 48'h0000_1234_5678);
        reset = 1'b0;
        cr_sr = '0; cr_exsr = '0; cr_spc = '0; cr_tea = '0;
        cr_vbr = 48'h8000; cr_sp = 48'h2000; cr_ssp = 48'h3000;
        step();

        // Exception entry
        cur_pc = 48'h1000; exc_code = 16'h8003; exc_tea = 64'hABCD; exc_req = 1'b1;
        exp_q.push_back('{is_exc: 1'b1, pc: 48'h8040, redir: 1'b1});
        step();
        check("esave_busy", busy, 1);
        check("esave_flush", flush, 1);
        check("esave_sp_wr", sp_wr, 1);
        check("esave_redir", redir, 0);
        check("esave_sp_val", sp_val, 48'h3000);
        check("esave_spc", out_spc, 48'h1000);
        check("esave_sr", out_sr, 64'h7000_0000);
        check("esave_ssp", out_ssp, 48'h2000);
        check("esave_exsr", out_exsr, 64'h8003);
        check("esave_tea", out_tea, 64'hABCD);
        drain(5);
        step();
        check("entry_idle", busy, 0);

        // Return from exception
        rte_req = 1'b1;
        exp_q.push_back('{is_exc: 1'b0, pc: 48'h1000, redir: 1'b1});
        step();
        check("rsave_sr_lo", out_sr[31:0], 0);
        check("rsave_sp_wr", sp_wr, 1);
        check("rsave_sp_val", sp_val, 48'h2000);
        check("rsave_ssp", out_ssp, 48'h3000);
        drain(5);
        step();
        check("rte_sp_restored", cr_sp, 48'h2000);
        check("rte_idle", busy, 0);

        // RTE outside an ISR: bare ack, no redirect, no SP write
        rte_req = 1'b1;
        exp_q.push_back('{is_exc: 1'b0, pc: 48'h0, redir: 1'b0});
        step();
        check("rte_noisr_sp_wr", sp_wr, 0);
        check("rte_noisr_busy", busy, 0);
        check("rte_noisr_pending", exp_q.size(), 0);
        step();
        check("rte_noisr_once", rte_ack, 0);

        // Simultaneous requests: exception first, then the pending RTE
        cur_pc = 48'h2468; exc_code = 16'h1005;
        exc_req = 1'b1; rte_req = 1'b1;
        exp_q.push_back('{is_exc: 1'b1, pc: 48'h8008, redir: 1'b1});
        exp_q.push_back('{is_exc: 1'b0, pc: 48'h2468, redir: 1'b1});
        drain(20);
        step();
        check("simul_idle", busy, 0);

        // Stall in E_SAVE, vector address wrapping at 48 bits
        cr_vbr = 48'hFFFF_FFFF_FFF8; exc_code = 16'hF000; exc_req = 1'b1;
        exp_q.push_back('{is_exc: 1'b1, pc: 48'h70, redir: 1'b1});
        step();
        redir_count = 0;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_sp_wr", sp_wr, 1);
            check("hold_redir", redir, 0);
        end
        hold = 1'b0;
        drain(10);
        step();
        step();
        check("hold_redir_once", redir_count, 1);

        // Double fault: SR.BL is still set from the last entry
        snap = n_exc_ack;
        exc_req = 1'b1;
        step();
        check("lock_lockup", lockup, 1);
        check("lock_busy", busy, 1);
        check("lock_strobes", {sp_wr, redir, flush}, 0);
        for (int i = 0; i < 100; i++) step();
        check("lock_no_ack", n_exc_ack - snap, 0);
        check("lock_held", lockup, 1);
        check("lock_sr_pass", out_sr, 64'h7000_0000);
        reset = 1'b1; exc_req = 1'b0;
        step();
        check("lock_cleared", lockup, 0);
        check("lock_rst_idle", busy, 0);
        reset = 1'b0;

        // Reset mid-sequence aborts without an ack
        cr_sr = '0; exc_req = 1'b1;
        step();
        check("abort_busy", busy, 1);
        reset = 1'b1; exc_req = 1'b0;
        snap = n_exc_ack;
        step();
        check("abort_idle", busy, 0);
        check("abort_strobes", {sp_wr, redir, flush, exc_ack, rte_ack}, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_no_ack", n_exc_ack - snap, 0);
        check("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/isr_trap_seq.md
ISR_TRAP_SEQ -- requirements
Module: isr_trap_seq

Interface
REQ-001 SHALL have parameter VEC_SHIFT, default 3: left shift applied to exc_code[15:12] to form the vector offset.
REQ-002 SHALL have port clock, in, 1: system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, in, 1: synchronous, active-high.
REQ-004 SHALL have port hold, in, 1: pipeline stall; when 1, all state and registered outputs are frozen.
REQ-005 SHALL have port exc_req, in, 1: exception request, held until exc_ack.
REQ-006 SHALL have port exc_code, in, 16: exception code; [15:12] is the vector class.
REQ-007 SHALL have port exc_tea, in, 64: faulting address.
REQ-008 SHALL have port rte_req, in, 1: return-from-exception request, held until rte_ack.
REQ-009 SHALL have port cur_pc, in, 48: PC of the faulting or RTE instruction.
REQ-010 SHALL have ports cur_sr (in, 64), cur_exsr (in, 64), cur_spc (in, 48), cur_ssp (in, 48), cur_tea (in, 64), cur_vbr (in, 48): current control-register values.
REQ-011 SHALL have port cur_sp, in, 48: current stack pointer (GPR R15).
REQ-012 SHALL have ports out_sr (out, 64), out_exsr (out, 64), out_spc (out, 48), out_ssp (out, 48), out_tea (out, 64): next control-register values, driven into the CR file's regIn* inputs.
REQ-013 SHALL have port sp_wr, out, 1: one-cycle R15 write strobe.
REQ-014 SHALL have port sp_val, out, 48: R15 write value.
REQ-015 SHALL have port redir, out, 1: one-cycle fetch redirect.
REQ-016 SHALL have port redir_pc, out, 48: redirect target.
REQ-017 SHALL have port flush, out, 1: flush EX1..EX3.
REQ-018 SHALL have ports exc_ack (out, 1) and rte_ack (out, 1): one-cycle request completions.
REQ-019 SHALL have port busy, out, 1: state is not IDLE.
REQ-020 SHALL have port lockup, out, 1: double-fault latch.

Function
REQ-021 SHALL implement the states IDLE, E_SAVE, E_REDIR, R_SAVE, R_REDIR and LOCK, with 3-bit state encoding.
REQ-022 SHALL, in IDLE and LOCK, pass every out_* through from its corresponding cur_*.
REQ-023 SHALL, in IDLE and LOCK, hold sp_wr, redir, flush, exc_ack and rte_ack at 0.
REQ-024 SHALL give priority to exc_req when exc_req and rte_req are both 1 in IDLE; the RTE remains pending and is accepted later.
REQ-025 SHALL, when exc_req is accepted in IDLE with cur_sr[28]=0, latch cur_pc, cur_sr, cur_sp, cur_ssp, exc_code, exc_tea and cur_vbr, and go to E_SAVE.
REQ-026 SHALL, when exc_req is seen in IDLE with cur_sr[28]=1 (double fault), go to LOCK, set lockup=1, and never assert exc_ack.
REQ-027 SHALL, in E_SAVE, drive: out_spc=latched pc; out_exsr={latched sr[31:0], 16'h0, latched code}; out_tea=latched tea; out_ssp=latched sp; sp_wr=1, sp_val=latched ssp; out_sr=latched sr with bits 30, 29 and 28 set.
REQ-028 SHALL go from E_SAVE to E_REDIR.
REQ-029 SHALL, in E_REDIR, assert redir=1 and exc_ack=1 with redir_pc=latched vbr + (code[15:12] << VBR shift VEC_SHIFT), computed modulo 2^48, then go to IDLE.
REQ-030 SHALL, when rte_req is accepted in IDLE with cur_sr[28]=1, latch cur_exsr, cur_spc, cur_sp, cur_ssp and cur_sr, and go to R_SAVE.
REQ-031 SHALL, when rte_req is seen in IDLE with cur_sr[28]=0, pulse rte_ack with redir=0 and perform no state change.
REQ-032 SHALL, in R_SAVE, drive: out_sr={latched sr[63:32], latched exsr[63:32]}; sp_wr=1, sp_val=latched ssp; out_ssp=latched sp; go to R_REDIR.
REQ-033 SHALL, in R_REDIR, assert redir=1 and rte_ack=1 with redir_pc=latched spc, then go to IDLE.
REQ-034 SHALL assert flush in E_SAVE, E_REDIR, R_SAVE and R_REDIR.
REQ-035 SHALL, in any of those four states, pass through every out_* not named for that state.
REQ-036 SHALL keep the total latency from acceptance to redir at exactly 2 unstalled cycles.
REQ-037 SHALL, when hold=1 in a non-IDLE state, keep the state and hold strobes at their current level; they still complete exactly once after hold falls.
REQ-038 SHALL keep LOCK until reset.

Reset
REQ-039 SHALL, on reset, set state to IDLE, clear lockup and all latches, and drive all strobes to 0; out_* then pass through on the same cycle.
REQ-040 SHALL let reset asserted mid-sequence abort the sequence with no ack issued.

Verification
REQ-041 SHALL cover exception entry: cur_sr=0, cur_pc=0x1000, cur_vbr=0x8000, exc_code=0x8003, cur_sp=0x2000, cur_ssp=0x3000 -> E_SAVE out_spc=0x1000, out_sr=0x70000000, sp_val=0x3000, out_ssp=0x2000; E_REDIR redir_pc=0x8040, exc_ack=1.
REQ-042 SHALL cover RTE round-trip: after REQ-041, rte_req -> out_sr[31:0]=0, sp_val=0x2000, redir_pc=0x1000, rte_ack=1.
REQ-043 SHALL cover a double fault: exc_req with cur_sr[28]=1 -> lockup=1 and no exc_ack for 100 cycles; reset clears it.
REQ-044 SHALL cover simultaneous requests: exc_req=rte_req=1 in IDLE -> exception sequence first, then the RTE sequence.
REQ-045 SHALL cover stall: hold=1 for 5 cycles in E_SAVE -> sp_wr stays 1 and redir pulses exactly once after release.
REQ-046 SHALL cover RTE outside an ISR: cur_sr[28]=0 -> rte_ack pulses, with redir=0 and sp_wr=0.
